// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one operation in flight,
// fixed XLEN-cycle latency, result written back to the register file.
module mul_div_unit #(
  parameter int XLEN       = 32,
  parameter int ADDRESSLEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       rs1_val,
  input  logic [XLEN-1:0]       rs2_val,
  input  logic [ADDRESSLEN-1:0] rd_in,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic [ADDRESSLEN-1:0] rd_out,
  output logic                  wEn
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [2*XLEN-1:0]       acc_q;
  logic [2*XLEN-1:0]       acc_d;
  logic [XLEN-1:0]         m_q;
  logic [2:0]              op_q;
  logic                    neg_q;
  logic                    nrem_q;
  logic                    div0_q;
  logic [ADDRESSLEN-1:0]   rd_q;
  logic [XLEN-1:0]         res_q;
  logic [XLEN-1:0]         res_d;
  logic                    busy_q;
  logic                    done_q;
  logic                    wen_q;

  logic                    sgn_a;
  logic                    sgn_b;
  logic                    a_neg;
  logic                    b_neg;
  logic [XLEN-1:0]         a_abs;
  logic [XLEN-1:0]         b_abs;

  logic [XLEN:0]           mul_sum;
  logic [XLEN+1:0]         div_diff;
  logic [2*XLEN-1:0]       prod;
  logic [XLEN-1:0]         quo;
  logic [XLEN-1:0]         rem;

  assign busy   = busy_q;
  assign done   = done_q;
  assign wEn    = wen_q;
  assign result = res_q;
  assign rd_out = rd_q;

  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM also rs2
  always_comb begin
    sgn_a = (funct3 == 3'd1) || (funct3 == 3'd2) ||
            (funct3 == 3'd4) || (funct3 == 3'd6);
    sgn_b = (funct3 == 3'd1) || (funct3 == 3'd4) ||
            (funct3 == 3'd6);
    a_neg = sgn_a & rs1_val[XLEN-1];
    b_neg = sgn_b & rs2_val[XLEN-1];
    a_abs = a_neg ? -rs1_val : rs1_val;
    b_abs = b_neg ? -rs2_val : rs2_val;
  end

  // acc holds {hi, lo}: product halves, or {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               (acc_q[0] ? {1'b0, m_q} : '0);
    div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, m_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN+1]) begin
        acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[2*XLEN-2:0], 1'b0};
      end
    end else begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod  = neg_q ? -acc_d : acc_d;
    quo   = div0_q ? '1 :
            (neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0]);
    rem   = nrem_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
    res_d = prod[XLEN-1:0];
    unique case (1'b1)
      (op_q == 3'd0):           res_d = prod[XLEN-1:0];
      (!op_q[2] && op_q != 0):  res_d = prod[2*XLEN-1:XLEN];
      (op_q[2] && !op_q[1]):    res_d = quo;
      (op_q[2] && op_q[1]):     res_d = rem;
      default:                  res_d = prod[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      nrem_q  <= 1'b0;
      div0_q  <= 1'b0;
      rd_q    <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          wen_q  <= 1'b0;
          if (start) begin
            op_q    <= funct3;
            rd_q    <= rd_in;
            neg_q   <= a_neg ^ b_neg;
            nrem_q  <= a_neg;
            div0_q  <= (rs2_val == '0);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
            if (funct3[2]) begin
              acc_q <= {{XLEN{1'b0}}, a_abs};
              m_q   <= b_abs;
            end else begin
              acc_q <= {{XLEN{1'b0}}, b_abs};
              m_q   <= a_abs;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            res_q   <= res_d;
            done_q  <= 1'b1;
            wen_q   <= (rd_q != '0);
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          wen_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: scoreboard of expected write-backs,
// latency, ignored-start and asynchronous-abort checks.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [3:0]  rd_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  rd_out;
  logic        wEn;

  mul_div_unit #(.XLEN(32), .ADDRESSLEN(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .funct3(funct3),
    .rs1_val(rs1_val),
    .rs2_val(rs2_val),
    .rd_in(rd_in),
    .busy(busy),
    .done(done),
    .result(result),
    .rd_out(rd_out),
    .wEn(wEn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        wen;
  } exp_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic [31:0] r;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] rd,
                       input logic [31:0] r);
    exp_t e;
    @(negedge clk);
    funct3  = f;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    start   = 1'b1;
    e.res = r;
    e.rd  = rd;
    e.wen = (rd != 4'd0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start   = 1'b0;
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_in   = 4'($urandom);
    funct3  = 3'($urandom);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_op(input string tag);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
    end
    chk({tag, "_latency"}, cyc, 32);
    e = sb.pop_front();
    chk({tag, "_result"}, result, e.res);
    chk({tag, "_rd"}, {28'd0, rd_out}, {28'd0, e.rd});
    chk({tag, "_wen"}, {31'd0, wEn}, {31'd0, e.wen});
    @(posedge clk);
    #1;
    chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_off"}, {31'd0, done}, 32'd0);
    chk({tag, "_result_held"}, result, e.res);
  endtask

  vec_t vecs[13] = '{
    '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 4'd5, 32'hFFFF_FFEB},
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'hFFFF_FFFE},
    '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'h0000_0000},
    '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 4'd4, 32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 4'd6, 32'hFFFF_FFFF},
    '{3'd5, 32'd100,       32'd7,         4'd7, 32'd14},
    '{3'd7, 32'd100,       32'd7,         4'd8, 32'd2},
    '{3'd5, 32'd13,        32'd0,         4'd9, 32'hFFFF_FFFF},
    '{3'd6, 32'd13,        32'd0,         4'd10, 32'd13},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd11, 32'h8000_0000},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 32'h0000_0000},
    '{3'd4, 32'd13,        32'd0,         4'd13, 32'hFFFF_FFFF}
  };

  initial begin
    int          ndone;
    int          nwen;
    int          dcyc;
    logic [31:0] dres;
    exp_t        e;

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wen", {31'd0, wEn}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", {28'd0, rd_out}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].r);
      finish_op($sformatf("op%0d_f%0d", i, vecs[i].f));
    end

    // start pulses while busy must not launch a second operation
    issue(3'd0, 32'd5, 32'd6, 4'd0, 32'd30);
    ndone = 0;
    nwen  = 0;
    dcyc  = 0;
    dres  = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        dcyc = i;
        dres = result;
      end
      if (wEn) nwen++;
      if (i == 3 || i == 20) begin
        start   = 1'b1;
        funct3  = 3'd0;
        rs1_val = 32'd9;
        rs2_val = 32'd9;
        rd_in   = 4'd7;
      end
    end
    e = sb.pop_front();
    chk("ign_done_count", ndone, 1);
    chk("ign_latency", dcyc, 32);
    chk("ign_result", dres, e.res);
    chk("ign_wen_count", nwen, 0);
    chk("ign_busy_end", {31'd0, busy}, 32'd0);

    // asynchronous abort in the middle of CALC
    issue(3'd0, 32'h0000_1234, 32'h0000_5678, 4'd9, 32'h0626_0060);
    void'(sb.pop_back());
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_wen", {31'd0, wEn}, 32'd0);
    chk("abort_result", result, 32'd0);
    nwen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (wEn) nwen++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (wEn || done) nwen++;
    end
    chk("abort_no_write", nwen, 0);

    issue(3'd0, 32'd3, 32'd4, 4'd1, 32'd12);
    finish_op("post_reset_mul");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
